// File: rtl/fp_multiplier_sp.sv
// IEEE-754 single-precision multiplier: iterative shift-add mantissa multiply (K bits/cycle),
// round-to-nearest-even, flush-to-zero on denormal inputs and underflowed results.
module fp_multiplier_sp #(
  parameter int unsigned K = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        NAN,
  output logic        INF,
  output logic        ZERO,
  output logic        subnormal
);

  localparam int unsigned N = 24 / K;

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StOut} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [47:0]       mcand_q, mcand_d;
  logic [47:0]       acc_q, acc_d;
  logic [23:0]       mplier_q, mplier_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              in_nan_q, in_nan_d;
  logic              in_inf_q, in_inf_d;
  logic              in_zero_q, in_zero_d;
  logic [31:0]       product_q, product_d;
  logic              nan_q, nan_d;
  logic              inf_q, inf_d;
  logic              zero_q, zero_d;
  logic              sub_q, sub_d;

  logic              accept;
  logic [47:0]       partial;
  logic              op1_max, op2_max, op1_zero, op2_zero;

  // Normalisation / rounding datapath, consumed on the NORM -> OUT edge
  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_norm, exp_fin;
  logic [31:0]       res_product;
  logic              res_nan, res_inf, res_zero, res_sub;

  assign accept   = start & ((state_q == StIdle) | (state_q == StOut));
  assign partial  = mcand_q * {{(48 - K){1'b0}}, mplier_q[K-1:0]};
  assign op1_max  = &OP1[30:23];
  assign op2_max  = &OP2[30:23];
  assign op1_zero = ~|OP1[30:23];
  assign op2_zero = ~|OP2[30:23];

  always_comb begin
    if (acc_q[47]) begin
      mant     = acc_q[46:24];
      guard    = acc_q[23];
      sticky   = |acc_q[22:0];
      exp_norm = exp_q + 10'sd1;
    end else begin
      mant     = acc_q[45:23];
      guard    = acc_q[22];
      sticky   = |acc_q[21:0];
      exp_norm = exp_q;
    end
    round_up = guard & (mant[0] | sticky);
    mant_rnd = {1'b0, mant} + {23'b0, round_up};
    // A carry out leaves the fraction all-zero, so only the exponent moves
    exp_fin  = exp_norm + $signed({9'b0, mant_rnd[23]});

    res_product = {sign_q, exp_fin[7:0], mant_rnd[22:0]};
    res_nan     = 1'b0;
    res_inf     = 1'b0;
    res_zero    = 1'b0;
    res_sub     = 1'b0;
    if (in_nan_q | (in_inf_q & in_zero_q)) begin
      res_product = 32'h7FC0_0000;
      res_nan     = 1'b1;
    end else if (in_inf_q | (exp_fin >= 10'sd255)) begin
      res_product = {sign_q, 8'hFF, 23'b0};
      res_inf     = 1'b1;
    end else if (in_zero_q | (exp_fin <= 10'sd0)) begin
      res_product = {sign_q, 31'b0};
      res_zero    = 1'b1;
      res_sub     = ~in_zero_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    in_nan_d  = in_nan_q;
    in_inf_d  = in_inf_q;
    in_zero_d = in_zero_q;
    product_d = product_q;
    nan_d     = nan_q;
    inf_d     = inf_q;
    zero_d    = zero_q;
    sub_d     = sub_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StMul: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(N - 1)) state_d = StNorm;
      end
      StNorm: begin
        state_d   = StOut;
        product_d = res_product;
        nan_d     = res_nan;
        inf_d     = res_inf;
        zero_d    = res_zero;
        sub_d     = res_sub;
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StMul;
      cnt_d     = 5'd0;
      acc_d     = 48'd0;
      mcand_d   = {24'b0, 1'b1, OP1[22:0]};
      mplier_d  = {1'b1, OP2[22:0]};
      exp_d     = $signed({2'b0, OP1[30:23]}) + $signed({2'b0, OP2[30:23]}) - 10'sd127;
      sign_d    = OP1[31] ^ OP2[31];
      in_nan_d  = (op1_max & |OP1[22:0]) | (op2_max & |OP2[22:0]);
      in_inf_d  = (op1_max & ~|OP1[22:0]) | (op2_max & ~|OP2[22:0]);
      in_zero_d = op1_zero | op2_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      mcand_q   <= 48'd0;
      acc_q     <= 48'd0;
      mplier_q  <= 24'd0;
      exp_q     <= 10'sd0;
      sign_q    <= 1'b0;
      in_nan_q  <= 1'b0;
      in_inf_q  <= 1'b0;
      in_zero_q <= 1'b0;
      product_q <= 32'd0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      in_nan_q  <= in_nan_d;
      in_inf_q  <= in_inf_d;
      in_zero_q <= in_zero_d;
      product_q <= product_d;
      nan_q     <= nan_d;
      inf_q     <= inf_d;
      zero_q    <= zero_d;
      sub_q     <= sub_d;
    end
  end

  assign busy      = (state_q == StMul) | (state_q == StNorm);
  assign done      = (state_q == StOut);
  assign product   = product_q;
  assign NAN       = nan_q;
  assign INF       = inf_q;
  assign ZERO      = zero_q;
  assign subnormal = sub_q;

endmodule

// File: tb/tb_fp_multiplier_sp.sv
// Self-checking bench for fp_multiplier_sp: directed corner cases plus randomized operands
// against an exact-integer reference model, on a K=1 and a K=4 instance.
module tb_fp_multiplier_sp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [31:0] a1, b1, a4, b4;
  logic        busy1, done1, nan1, inf1, zero1, sub1;
  logic        busy4, done4, nan4, inf4, zero4, sub4;
  logic [31:0] prod1, prod4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_multiplier_sp #(.K(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .OP1(a1), .OP2(b1),
    .busy(busy1), .done(done1), .product(prod1),
    .NAN(nan1), .INF(inf1), .ZERO(zero1), .subnormal(sub1)
  );

  fp_multiplier_sp #(.K(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .OP1(a4), .OP2(b4),
    .busy(busy4), .done(done4), .product(prod4),
    .NAN(nan4), .INF(inf4), .ZERO(zero4), .subnormal(sub4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // {NAN, INF, ZERO, subnormal, product}
  function automatic logic [35:0] obs(input bit u4);
    if (u4) return {nan4, inf4, zero4, sub4, prod4};
    return {nan1, inf1, zero1, sub1, prod1};
  endfunction

  // Exact product of the two significands, then round-to-nearest-even by remainder comparison
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    bit an, bn, ai, bi, az, bz;
    longint unsigned p, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC0_0000};
    if (ai || bi) return {4'b0100, s, 8'hFF, 23'b0};
    if (az || bz) return {4'b0010, s, 31'b0};
    p = {40'b0, 1'b1, a[22:0]};
    p = p * {40'b0, 1'b1, b[22:0]};
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = ea + eb - 126;
    end else begin
      sh = 23;
      e  = ea + eb - 127;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {4'b0100, s, 8'hFF, 23'b0};
    if (e <= 0) return {4'b0011, s, 31'b0};
    return {4'b0000, s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned r;
    logic [31:0] v;
    r = $urandom_range(0, 19);
    v = $urandom;
    case (r)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'h00; v[22:0] = 23'd0; end
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      4, 5, 6: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  task automatic wait_done(input bit u4, output int lat);
    lat = 0;
    while (!(u4 ? done4 : done1) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit u4, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [35:0] exp_r, got;
    int lat;
    exp_r = ref_mul(a, b);
    @(posedge clk);
    #1;
    if (u4) begin a4 = a; b4 = b; start4 = 1'b1; end
    else begin a1 = a; b1 = b; start1 = 1'b1; end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    wait_done(u4, lat);
    got = obs(u4);
    check_val({tag, "_lat"}, lat, u4 ? 32'd7 : 32'd25);
    check_val({tag, "_prod"}, got[31:0], exp_r[31:0]);
    check_val({tag, "_flags"}, {28'b0, got[35:32]}, {28'b0, exp_r[35:32]});
  endtask

  initial begin
    logic [35:0] exp_r, got;
    int lat, ndone;
    rst = 1'b1;
    start1 = 1'b0; start4 = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ctl1", {30'b0, busy1, done1}, 32'd0);
    check_val("rst_out1", obs(0)[31:0] | {28'b0, obs(0)[35:32]}, 32'd0);
    check_val("rst_ctl4", {30'b0, busy4, done4}, 32'd0);
    rst = 1'b0;

    // Directed corners on K=1 and the T1/T2 set on K=4
    run_op(0, 32'h3FC0_0000, 32'h4000_0000, "t1");
    run_op(0, 32'hBF80_0000, 32'h3F00_0000, "t2a");
    run_op(0, 32'h3F80_0001, 32'h3F80_0001, "t2b_rne");
    run_op(0, 32'h7F80_0000, 32'h0000_0000, "t3_nan");
    run_op(0, 32'h7F00_0000, 32'h7F00_0000, "t3_ovf");
    run_op(0, 32'h0080_0000, 32'h3F00_0000, "t4_unf");
    run_op(0, 32'h0000_0001, 32'h3F80_0000, "t4_den");
    run_op(0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, "rnd_carry");
    run_op(1, 32'h3FC0_0000, 32'h4000_0000, "k4_t1");
    run_op(1, 32'hBF80_0000, 32'h3F00_0000, "k4_t2a");
    run_op(1, 32'h3F80_0001, 32'h3F80_0001, "k4_t2b");

    // Start while busy is ignored; operands change freely after accept
    exp_r = ref_mul(32'h4040_0000, 32'hC0A0_0000);
    @(posedge clk);
    #1;
    a1 = 32'h4040_0000; b1 = 32'hC0A0_0000; start1 = 1'b1;
    @(posedge clk);
    #1;
    check_val("t5_busy", {31'b0, busy1}, 32'd1);
    a1 = 32'h7F80_0000; b1 = 32'h0000_0000;
    lat = 0;
    while (!done1 && lat < 40) begin
      if (lat == 3) start1 = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    got = obs(0);
    check_val("t5_ign_lat", lat, 32'd25);
    check_val("t5_ign_prod", got[31:0], exp_r[31:0]);
    // Start held in the done cycle is accepted back-to-back
    exp_r = ref_mul(32'h4110_0000, 32'h3E80_0000);
    a1 = 32'h4110_0000; b1 = 32'h3E80_0000; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check_val("t5_b2b_busy", {31'b0, busy1}, 32'd1);
    wait_done(0, lat);
    got = obs(0);
    check_val("t5_b2b_lat", lat, 32'd25);
    check_val("t5_b2b_prod", got[31:0], exp_r[31:0]);

    // Reset mid-MUL aborts with no done
    @(posedge clk);
    #1;
    a1 = 32'h4000_0000; b1 = 32'h4000_0000; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("t6_busy", {30'b0, busy1, done1}, 32'd0);
    check_val("t6_prod", prod1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) ndone++;
    end
    check_val("t6_nodone", ndone, 32'd0);
    run_op(0, 32'h3FC0_0000, 32'h4000_0000, "t6_after");

    for (int i = 0; i < 150; i++) run_op(0, rand_op(), rand_op(), $sformatf("rnd1_%0d", i));
    for (int i = 0; i < 40; i++) run_op(1, rand_op(), rand_op(), $sformatf("rnd4_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
